// File: rtl/backing_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : backing_memory_if
// Description : Block request/response bundle between the data cache miss /
//               writeback path (master) and the backing memory (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface backing_memory_if;
  logic        memReq;
  logic        memWrite;
  logic [28:0] blockAddress;
  logic [63:0] writeBlock;
  logic [63:0] readBlock;
  logic        memReady;
  logic        memBusy;

  modport master (
    output memReq, memWrite, blockAddress, writeBlock,
    input  readBlock, memReady, memBusy
  );

  modport slave (
    input  memReq, memWrite, blockAddress, writeBlock,
    output readBlock, memReady, memBusy
  );
endinterface
`default_nettype wire

// File: rtl/backing_memory.sv
`default_nettype none
// ============================================================================
// Module      : backing_memory
// Description : Fixed-latency 64-bit block memory. Accepts one block read or
//               write while idle, waits LATENCY cycles, then pulses memReady
//               for one cycle. Writes commit on the edge leaving RESPOND.
// Revision    : 1.0  initial release
// ============================================================================
module backing_memory #(
  parameter int LATENCY      = 4,
  parameter int DEPTH_BLOCKS = 128
) (
  input  logic             clk,
  input  logic             reset,
  backing_memory_if.slave  bus
);

  localparam int         c_indexBits   = $clog2(DEPTH_BLOCKS);
  localparam logic [7:0] c_latencyLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [7:0]             r_counter;
  logic                   r_write;
  logic [c_indexBits-1:0] r_index;
  logic [63:0]            r_writeData;
  logic [63:0]            r_readBlock;
  logic                   w_accept;
  logic                   w_write;
  logic [c_indexBits-1:0] w_index;

  // Storage starts at zero and is deliberately left untouched by reset.
  logic [63:0] r_mem [DEPTH_BLOCKS] = '{default: '0};

  // Address bits above the index alias onto the same entry.
  generate
    if (c_indexBits < 29) begin : g_unusedAddr
      logic unusedAddrBits;
      assign unusedAddrBits = ^bus.blockAddress[28:c_indexBits];
    end
  endgenerate

  // Next-state decode; a request is only taken while idle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.memReq) begin
          w_accept    = 1'b1;
          w_nextState = (LATENCY == 1) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        if (r_counter == 8'd1) begin
          w_nextState = RESPOND;
        end
      end
      RESPOND: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Effective request fields: live inputs on the accept edge, latched copies after.
  always_comb begin
    w_write = w_accept ? bus.memWrite : r_write;
    w_index = w_accept ? bus.blockAddress[c_indexBits-1:0] : r_index;
  end

  // State, latency counter, request latches and the read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_counter   <= 8'd0;
      r_write     <= 1'b0;
      r_index     <= '0;
      r_writeData <= 64'd0;
      r_readBlock <= 64'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_write     <= bus.memWrite;
        r_index     <= bus.blockAddress[c_indexBits-1:0];
        r_writeData <= bus.writeBlock;
        r_counter   <= c_latencyLoad;
      end else if (r_state == WAIT) begin
        r_counter <= r_counter - 8'd1;
      end
      // Load read data on the edge entering RESPOND so it is valid with memReady.
      if (w_nextState == RESPOND && !w_write) begin
        r_readBlock <= r_mem[w_index];
      end
    end
  end

  // Write commit on the edge leaving RESPOND; a reset there aborts it.
  always_ff @(posedge clk) begin
    if (!reset && r_state == RESPOND && r_write) begin
      r_mem[r_index] <= r_writeData;
    end
  end

  assign bus.readBlock = r_readBlock;
  assign bus.memReady  = (r_state == RESPOND);
  assign bus.memBusy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_backing_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_backing_memory
// Description : Self-checking bench for backing_memory. Three instances cover
//               LATENCY=4/DEPTH=128, LATENCY=4/DEPTH=16 and LATENCY=1.
//               Expected responses are queued at request time and popped
//               when memReady is seen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_backing_memory;

  typedef struct packed {
    logic        isWrite;
    logic [63:0] data;
  } expEntry_t;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;
  expEntry_t expQ[$];

  backing_memory_if ifA ();
  backing_memory_if ifB ();
  backing_memory_if ifC ();

  backing_memory #(.LATENCY(4), .DEPTH_BLOCKS(128)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  backing_memory #(.LATENCY(4), .DEPTH_BLOCKS(16))  dutB (.clk(clk), .reset(reset), .bus(ifB));
  backing_memory #(.LATENCY(1), .DEPTH_BLOCKS(128)) dutC (.clk(clk), .reset(reset), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic req, input logic wr,
                       input logic [28:0] addr, input logic [63:0] data);
    case (which)
      0: begin ifA.memReq = req; ifA.memWrite = wr; ifA.blockAddress = addr; ifA.writeBlock = data; end
      1: begin ifB.memReq = req; ifB.memWrite = wr; ifB.blockAddress = addr; ifB.writeBlock = data; end
      default: begin ifC.memReq = req; ifC.memWrite = wr; ifC.blockAddress = addr; ifC.writeBlock = data; end
    endcase
  endtask

  task automatic sample(input int which, output logic rdy, output logic busy, output logic [63:0] rb);
    case (which)
      0: begin rdy = ifA.memReady; busy = ifA.memBusy; rb = ifA.readBlock; end
      1: begin rdy = ifB.memReady; busy = ifB.memBusy; rb = ifB.readBlock; end
      default: begin rdy = ifC.memReady; busy = ifC.memBusy; rb = ifC.readBlock; end
    endcase
  endtask

  // Returns how many edges passed before memReady was seen, or -1 on timeout.
  task automatic waitReady(input int which, input int maxTicks, output int ticks);
    logic rdy, busy;
    logic [63:0] rb;
    logic found;
    found = 1'b0;
    ticks = -1;
    for (int t = 0; t <= maxTicks && !found; t++) begin
      if (t > 0) tick();
      sample(which, rdy, busy, rb);
      if (rdy === 1'b1) begin
        found = 1'b1;
        ticks = t;
      end
    end
  endtask

  task automatic popExp(output expEntry_t e);
    if (expQ.size() > 0) e = expQ.pop_front();
    else e = '{isWrite: 1'b0, data: 64'hFFFF_FFFF_FFFF_FFFF};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 29'h0B, 64'd0);
    drive(1, 1'b1, 1'b0, 29'h0B, 64'd0);
    drive(2, 1'b1, 1'b0, 29'h0B, 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      nCompared++;
      if (ifA.memReady !== 1'b0 || ifA.memBusy !== 1'b0 || ifA.readBlock !== 64'd0) begin
        nMismatched++;
        $display("FAIL reset_A: ready=%b busy=%b rb=%h, required 0/0/0", ifA.memReady, ifA.memBusy, ifA.readBlock);
      end
      nCompared++;
      if (ifC.memReady !== 1'b0 || ifC.memBusy !== 1'b0 || ifC.readBlock !== 64'd0) begin
        nMismatched++;
        $display("FAIL reset_C: ready=%b busy=%b rb=%h, required 0/0/0", ifC.memReady, ifC.memBusy, ifC.readBlock);
      end
    end
    drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 29'd0, 64'd0);
    drive(2, 1'b0, 1'b0, 29'd0, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    nCompared++;
    if (ifA.memBusy !== 1'b0 || ifB.memBusy !== 1'b0 || ifC.memBusy !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_release_busy: A=%b B=%b C=%b, required 0", ifA.memBusy, ifB.memBusy, ifC.memBusy);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] d;
    int t;
    expEntry_t e;
    d = 64'h04040404_DEADBEEF;
    drive(0, 1'b1, 1'b1, 29'h0B, d);
    expQ.push_back('{isWrite: 1'b1, data: d});
    tick();
    drive(0, 1'b0, 1'b0, 29'h0B, 64'd0);
    nCompared++;
    if (ifA.memBusy !== 1'b1 || ifA.memReady !== 1'b0) begin
      nMismatched++;
      $display("FAIL wr_accept: busy=%b ready=%b, required 1/0", ifA.memBusy, ifA.memReady);
    end
    waitReady(0, 10, t);
    nCompared++;
    if (t !== 3) begin
      nMismatched++;
      $display("FAIL wr_latency: ready after %0d edges, required 3", t);
    end
    popExp(e);
    tick();
    nCompared++;
    if (ifA.memReady !== 1'b0 || ifA.memBusy !== 1'b0) begin
      nMismatched++;
      $display("FAIL wr_done: ready=%b busy=%b, required 0/0", ifA.memReady, ifA.memBusy);
    end
    drive(0, 1'b1, 1'b0, 29'h0B, 64'd0);
    expQ.push_back('{isWrite: 1'b0, data: d});
    tick();
    drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
    waitReady(0, 10, t);
    nCompared++;
    if (t !== 3) begin
      nMismatched++;
      $display("FAIL rd_latency: ready after %0d edges, required 3", t);
    end
    popExp(e);
    nCompared++;
    if (ifA.readBlock !== e.data) begin
      nMismatched++;
      $display("FAIL rd_data: got %h, required %h", ifA.readBlock, e.data);
    end
    tick();
    nCompared++;
    if (ifA.memReady !== 1'b0 || ifA.readBlock !== d) begin
      nMismatched++;
      $display("FAIL rd_hold: ready=%b rb=%h, required 0/%h", ifA.memReady, ifA.readBlock, d);
    end
  endtask

  task automatic test_held_request();
    logic expReady, expBusy;
    expEntry_t e;
    drive(0, 1'b1, 1'b0, 29'h0B, 64'd0);
    repeat (3) expQ.push_back('{isWrite: 1'b0, data: 64'h04040404_DEADBEEF});
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (c == 11) drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
      expReady = (c == 3 || c == 8 || c == 13);
      expBusy  = !(c == 4 || c == 9 || c == 14);
      nCompared++;
      if (ifA.memReady !== expReady || ifA.memBusy !== expBusy) begin
        nMismatched++;
        $display("FAIL held_c%0d: ready=%b busy=%b, required %b/%b", c, ifA.memReady, ifA.memBusy, expReady, expBusy);
      end
      if (ifA.memReady === 1'b1) begin
        popExp(e);
        nCompared++;
        if (ifA.readBlock !== e.data) begin
          nMismatched++;
          $display("FAIL held_data_c%0d: got %h, required %h", c, ifA.readBlock, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    expEntry_t e;
    drive(0, 1'b1, 1'b1, 29'h201, 64'h99999999_99999999);
    tick();
    drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nCompared++;
    if (ifA.memBusy !== 1'b0 || ifA.memReady !== 1'b0) begin
      nMismatched++;
      $display("FAIL rstmid_abort: busy=%b ready=%b, required 0/0", ifA.memBusy, ifA.memReady);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      nCompared++;
      if (ifA.memReady !== 1'b0) begin
        nMismatched++;
        $display("FAIL rstmid_nopulse_c%0d: ready=%b, required 0", c, ifA.memReady);
      end
    end
    drive(0, 1'b1, 1'b0, 29'h201, 64'd0);
    expQ.push_back('{isWrite: 1'b0, data: 64'd0});
    tick();
    drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
    waitReady(0, 10, t);
    nCompared++;
    if (t !== 3) begin
      nMismatched++;
      $display("FAIL rstmid_latency: ready after %0d edges, required 3", t);
    end
    popExp(e);
    nCompared++;
    if (ifA.readBlock !== e.data) begin
      nMismatched++;
      $display("FAIL rstmid_data: got %h, required %h", ifA.readBlock, e.data);
    end
    tick();
  endtask

  task automatic test_alias();
    int t;
    expEntry_t e;
    drive(1, 1'b1, 1'b1, 29'h05, 64'h00000005_00000005);
    expQ.push_back('{isWrite: 1'b1, data: 64'h00000005_00000005});
    tick();
    drive(1, 1'b0, 1'b0, 29'd0, 64'd0);
    waitReady(1, 10, t);
    nCompared++;
    if (t !== 3) begin
      nMismatched++;
      $display("FAIL alias_wr_latency: ready after %0d edges, required 3", t);
    end
    popExp(e);
    tick();
    drive(1, 1'b1, 1'b0, 29'h15, 64'd0);
    expQ.push_back('{isWrite: 1'b0, data: 64'h00000005_00000005});
    tick();
    drive(1, 1'b0, 1'b0, 29'd0, 64'd0);
    waitReady(1, 10, t);
    nCompared++;
    if (t !== 3) begin
      nMismatched++;
      $display("FAIL alias_rd_latency: ready after %0d edges, required 3", t);
    end
    popExp(e);
    nCompared++;
    if (ifB.readBlock !== e.data) begin
      nMismatched++;
      $display("FAIL alias_data: got %h, required %h", ifB.readBlock, e.data);
    end
    tick();
  endtask

  task automatic test_latency1();
    int t;
    logic expReady;
    expEntry_t e;
    drive(2, 1'b1, 1'b1, 29'h03, 64'h11223344_55667788);
    expQ.push_back('{isWrite: 1'b1, data: 64'h11223344_55667788});
    tick();
    drive(2, 1'b0, 1'b0, 29'd0, 64'd0);
    waitReady(2, 5, t);
    nCompared++;
    if (t !== 0) begin
      nMismatched++;
      $display("FAIL lat1_wr_latency: ready after %0d edges, required 0", t);
    end
    popExp(e);
    tick();
    nCompared++;
    if (ifC.memBusy !== 1'b0 || ifC.memReady !== 1'b0) begin
      nMismatched++;
      $display("FAIL lat1_idle: busy=%b ready=%b, required 0/0", ifC.memBusy, ifC.memReady);
    end
    drive(2, 1'b1, 1'b0, 29'h03, 64'd0);
    repeat (3) expQ.push_back('{isWrite: 1'b0, data: 64'h11223344_55667788});
    for (int c = 0; c <= 5; c++) begin
      tick();
      if (c == 4) drive(2, 1'b0, 1'b0, 29'd0, 64'd0);
      expReady = ((c % 2) == 0) && (c <= 4);
      nCompared++;
      if (ifC.memReady !== expReady || ifC.memBusy !== expReady) begin
        nMismatched++;
        $display("FAIL lat1_b2b_c%0d: ready=%b busy=%b, required %b/%b", c, ifC.memReady, ifC.memBusy, expReady, expReady);
      end
      if (ifC.memReady === 1'b1) begin
        popExp(e);
        nCompared++;
        if (ifC.readBlock !== e.data) begin
          nMismatched++;
          $display("FAIL lat1_data_c%0d: got %h, required %h", c, ifC.readBlock, e.data);
        end
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    drive(0, 1'b0, 1'b0, 29'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 29'd0, 64'd0);
    drive(2, 1'b0, 1'b0, 29'd0, 64'd0);
    test_reset();
    test_write_read();
    test_held_request();
    test_reset_mid();
    test_alias();
    test_latency1();
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
